// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// reset PC and default geometry.
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMiss = 2'd1,
        StFill = 2'd2
    } state_e;

    localparam logic [31:0] ResetPc          = 32'h0000_1000;
    localparam int unsigned DefaultLines     = 4;
    localparam int unsigned DefaultLineWords = 4;
    localparam int unsigned DefaultAddrW     = 32;

    // Tag bits left over once the byte, word-offset and index fields are removed.
    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines,
                                              input int unsigned line_words);
        return addr_w - $clog2(lines) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage for the instruction cache: combinational lookup,
// single-line refill write and whole-array flush.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int unsigned LINES = DefaultLines,
    parameter int unsigned IDX_W = $clog2(LINES),
    parameter int unsigned TAG_W = 26
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_valid_i
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];

    // A refill in the flush cycle carries wr_valid_i=0, so write-after-clear is safe.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end
        if (wr_en_i) begin
            valid_d[wr_idx_i] = wr_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign hit_o = valid_q[lookup_idx_i] && (tag_q[lookup_idx_i] == lookup_tag_i);

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line refill handshake.
// Define ICACHE_STATS_EN to add hit/miss counter outputs.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = DefaultLines,
    parameter int unsigned LINE_WORDS = DefaultLineWords,
    parameter int unsigned ADDR_W     = DefaultAddrW
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,
    input  logic [ADDR_W-1:0]       pc_i,
    input  logic                    flush_i,
    output logic [31:0]             instr_o,
    output logic                    valid_o,
    output logic                    stall_o,
    output logic                    mem_req_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic                    mem_ready_i,
`ifdef ICACHE_STATS_EN
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o,
`endif
    input  logic [32*LINE_WORDS-1:0] mem_data_i
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = tag_width(ADDR_W, LINES, LINE_WORDS);
    localparam int unsigned LINE_W = 32 * LINE_WORDS;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [1:0]       unused_pc_lsb;

    assign pc_off        = pc_i[OFF_W+1:2];
    assign pc_idx        = pc_i[OFF_W+2 +: IDX_W];
    assign pc_tag        = pc_i[ADDR_W-1 -: TAG_W];
    assign unused_pc_lsb = pc_i[1:0];

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flush_pend_q, flush_pend_d;

    logic              hit;
    logic              fill_en;
    logic              fill_valid;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    assign fill_idx = addr_q[OFF_W+2 +: IDX_W];
    assign fill_tag = addr_q[ADDR_W-1 -: TAG_W];

    icache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .lookup_idx_i (pc_idx),
        .lookup_tag_i (pc_tag),
        .hit_o        (hit),
        .flush_i      (flush_i),
        .wr_en_i      (fill_en),
        .wr_idx_i     (fill_idx),
        .wr_tag_i     (fill_tag),
        .wr_valid_i   (fill_valid)
    );

    // Next-state logic; a flush seen anywhere in MISS keeps the refilled line invalid.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
        fill_en      = 1'b0;
        fill_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
                flush_pend_d = 1'b0;
                if (!hit) begin
                    state_d = StMiss;
                    req_d   = 1'b1;
                    addr_d  = {pc_tag, pc_idx, {(OFF_W + 2){1'b0}}};
                end
            end
            StMiss: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ready_i) begin
                    fill_en    = 1'b1;
                    fill_valid = !(flush_i || flush_pend_q);
                    req_d      = 1'b0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] rd_line;
    logic [31:0]       rd_word;

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[fill_idx] <= mem_data_i;
        end
    end

    assign rd_line = data_q[pc_idx];
    assign rd_word = rd_line[32*pc_off +: 32];

    assign valid_o    = (state_q == StIdle) && hit;
    assign stall_o    = !valid_o;
    assign instr_o    = valid_o ? rd_word : 32'h0;
    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (valid_o) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == StIdle) && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (LINES=4, LINE_WORDS=4); memory word
// at address A returns A ^ 32'h5A5A0000.
module tb_icache;
    import icache_pkg::*;

    logic         clk;
    logic         rsn_i;
    logic [31:0]  pc_i;
    logic         flush_i;
    logic [31:0]  instr_o;
    logic         valid_o;
    logic         stall_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i;
    logic [127:0] mem_data_i;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    icache #(
        .LINES      (4),
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) dut (
        .clk_i       (clk),
        .rsn_i       (rsn_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .instr_o     (instr_o),
        .valid_o     (valid_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ready_i (mem_ready_i),
`ifdef ICACHE_STATS_EN
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt),
`endif
        .mem_data_i  (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            l[32*i +: 32] = (a + 32'(4 * i)) ^ 32'h5A5A_0000;
        end
        return l;
    endfunction

    // Memory responder: waits for the request, answers after lat MISS cycles,
    // optionally pulses flush_i in MISS cycle fk, and stops in the IDLE cycle after FILL.
    task automatic serve_miss(input int lat, input int fk, output bit ok,
                              output logic [31:0] addr, output bit stable, output int stalls);
        ok     = 1'b0;
        stable = 1'b1;
        stalls = 0;
        addr   = 32'hx;
        for (int n = 0; n < 8 && mem_req_o !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        if (mem_req_o !== 1'b1) return;
        addr = mem_addr_o;
        for (int k = 0; k <= lat; k++) begin
            flush_i = (k == fk);
            if (k == lat) begin
                mem_data_i  = line_of(mem_addr_o);
                mem_ready_i = 1'b1;
            end
            if (mem_addr_o !== addr || mem_req_o !== 1'b1) stable = 1'b0;
            if (stall_o) stalls++;
            @(negedge clk); #1;
        end
        flush_i     = 1'b0;
        mem_ready_i = 1'b0;
        mem_data_i  = '0;
        if (mem_req_o !== 1'b0) stable = 1'b0;
        if (stall_o) stalls++;
        @(negedge clk); #1;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rsn_i = 1'b0; pc_i = ResetPc; flush_i = 1'b0; mem_ready_i = 1'b0; mem_data_i = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b want=0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", mem_addr_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", valid_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall got=%0b want=1", stall_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", instr_o); end
        rsn_i = 1'b1;
    endtask

    task automatic test_cold_miss();
        bit ok, stable; logic [31:0] a; int st;
        checks++; if (valid_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++; $display("FAIL cold_lookup valid=%0b stall=%0b want valid=0 stall=1", valid_o, stall_o); end
        serve_miss(3, -1, ok, a, stable, st);
        checks++; if (!ok) begin errors++; $display("FAIL cold_req_timeout got=no request want=request"); end
        checks++; if (a !== 32'h1000) begin errors++; $display("FAIL cold_addr got=%h want=00001000", a); end
        checks++; if (!stable) begin errors++; $display("FAIL cold_req_hold got=changed want=held"); end
        checks++; if (st != 5) begin errors++; $display("FAIL cold_stall_cycles got=%0d want=5", st); end
        checks++; if (valid_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL cold_hit valid=%0b stall=%0b want valid=1 stall=0", valid_o, stall_o); end
        checks++; if (instr_o !== 32'h5A5A1000) begin errors++; $display("FAIL cold_instr got=%h want=5a5a1000", instr_o); end
    endtask

    task automatic test_same_line_hits();
        logic [31:0] exp [3];
        exp[0] = 32'h5A5A1004; exp[1] = 32'h5A5A1008; exp[2] = 32'h5A5A100C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pc_i = 32'h1004 + 32'(4 * i);
            #1;
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL hit%0d_valid got=%0b want=1", i + 1, valid_o); end
            checks++; if (instr_o !== exp[i]) begin errors++; $display("FAIL hit%0d_instr got=%h want=%h", i + 1, instr_o, exp[i]); end
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL hit%0d_req got=%0b want=0", i + 1, mem_req_o); end
        end
    endtask

    task automatic test_conflict();
        bit ok, stable; logic [31:0] a; int st;
        @(negedge clk); pc_i = 32'h1040; #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL conflict_miss got=%0b want=0", valid_o); end
        serve_miss(0, -1, ok, a, stable, st);
        checks++; if (!ok || a !== 32'h1040) begin errors++; $display("FAIL conflict_addr ok=%0b got=%h want=00001040", ok, a); end
        checks++; if (st != 2) begin errors++; $display("FAIL conflict_stall_cycles got=%0d want=2", st); end
        checks++; if (valid_o !== 1'b1 || instr_o !== 32'h5A5A1040) begin
            errors++; $display("FAIL conflict_hit valid=%0b instr=%h want 1/5a5a1040", valid_o, instr_o); end
        @(negedge clk); pc_i = 32'h1000; #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL evicted_miss got=%0b want=0", valid_o); end
        serve_miss(1, -1, ok, a, stable, st);
        checks++; if (!ok || a !== 32'h1000 || st != 3) begin
            errors++; $display("FAIL refetch ok=%0b addr=%h stalls=%0d want 1/00001000/3", ok, a, st); end
        checks++; if (valid_o !== 1'b1 || instr_o !== 32'h5A5A1000) begin
            errors++; $display("FAIL refetch_hit valid=%0b instr=%h want 1/5a5a1000", valid_o, instr_o); end
    endtask

    task automatic test_flush_idle();
        bit ok, stable; logic [31:0] a; int st;
        @(negedge clk); flush_i = 1'b1; #1;
        checks++; if (valid_o !== 1'b1 || instr_o !== 32'h5A5A1000) begin
            errors++; $display("FAIL flush_same_cycle valid=%0b instr=%h want 1/5a5a1000", valid_o, instr_o); end
        @(negedge clk); flush_i = 1'b0; #1;
        checks++; if (valid_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++; $display("FAIL flush_next_miss valid=%0b stall=%0b want 0/1", valid_o, stall_o); end
        serve_miss(0, -1, ok, a, stable, st);
        checks++; if (!ok || valid_o !== 1'b1) begin errors++; $display("FAIL flush_refill ok=%0b valid=%0b want 1/1", ok, valid_o); end
    endtask

    task automatic test_flush_miss();
        bit ok, stable; logic [31:0] a; int st;
        @(negedge clk); pc_i = 32'h1010; #1;
        serve_miss(2, 1, ok, a, stable, st);
        checks++; if (!ok || a !== 32'h1010 || !stable) begin
            errors++; $display("FAIL flush_miss_handshake ok=%0b addr=%h stable=%0b want 1/00001010/1", ok, a, stable); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_miss_line_invalid got=%0b want=0", valid_o); end
        serve_miss(0, -1, ok, a, stable, st);
        checks++; if (!ok || valid_o !== 1'b1 || instr_o !== 32'h5A5A1010) begin
            errors++; $display("FAIL flush_miss_retry ok=%0b valid=%0b instr=%h want 1/1/5a5a1010", ok, valid_o, instr_o); end
    endtask

    task automatic test_reset_mid_miss();
        bit ok, stable; logic [31:0] a; int st;
        @(negedge clk); pc_i = 32'h1020; #1;
        for (int n = 0; n < 4 && mem_req_o !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rmm_req_rise got=%0b want=1", mem_req_o); end
        rsn_i = 1'b0;
        @(negedge clk); #1;
        checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rmm_req_drop req=%0b addr=%h want 0/00000000", mem_req_o, mem_addr_o); end
        rsn_i = 1'b1;
        checks++; if (valid_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++; $display("FAIL rmm_relookup valid=%0b stall=%0b want 0/1", valid_o, stall_o); end
        serve_miss(1, -1, ok, a, stable, st);
        checks++; if (!ok || a !== 32'h1020 || valid_o !== 1'b1 || instr_o !== 32'h5A5A1020) begin
            errors++; $display("FAIL rmm_refill ok=%0b addr=%h valid=%0b instr=%h want 1/00001020/1/5a5a1020",
                               ok, a, valid_o, instr_o); end
        @(negedge clk); pc_i = 32'h1000; #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmm_old_line_cleared got=%0b want=0", valid_o); end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        bit ok, stable; logic [31:0] a; int st;
        rsn_i = 1'b0; pc_i = ResetPc;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_reset hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        rsn_i = 1'b1;
        serve_miss(0, -1, ok, a, stable, st);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); pc_i = 32'h1004 + 32'(4 * i);
        end
        @(negedge clk); #1;
        checks++; if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1) begin
            errors++; $display("FAIL stats_counts hit=%0d miss=%0d want 4/1", hit_cnt, miss_cnt); end
        // The flush cycle itself is still an IDLE hit, so hits reach 5.
        flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0; #1;
        checks++; if (hit_cnt !== 32'd5 || miss_cnt !== 32'd1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL stats_after_flush hit=%0d miss=%0d valid=%0b want 5/1/0",
                               hit_cnt, miss_cnt, valid_o); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line_hits();
        test_conflict();
        test_flush_idle();
        test_flush_miss();
        test_reset_mid_miss();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
